// File: rtl/wts_slot_bridge.sv
`default_nettype none
// ============================================================================
// Module      : wts_slot_bridge
// Description : MSX cartridge-slot front-end for the Wave Table Sound core.
//               Synchronises the slot read/write strobes, posts writes to
//               the core through a small FIFO, orders reads behind pending
//               writes, raises slot wait-state while read data is not ready,
//               and registers a multi-mode stereo output mixer.
// Revision    : 1.0 - initial release
// ============================================================================
module wts_slot_bridge #(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_W      = 15,
   parameter int FIFO_DEPTH  = 4,
   parameter int OUT_W       = 12
) (
   input  logic              clk,
   input  logic              slot_nreset,
   // slot side
   input  logic [ADDR_W-1:0] slot_a,
   input  logic [7:0]        slot_d_in,
   output logic [7:0]        slot_d_out,
   output logic              slot_d_oe,
   input  logic              slot_nsltsl,
   input  logic              slot_nmerq,
   input  logic              slot_nrd,
   input  logic              slot_nwr,
   output logic              slot_nwait,
   // core side
   output logic              core_wrreq,
   input  logic              core_wr_ready,
   output logic              core_rdreq,
   input  logic              core_rvalid,
   output logic [ADDR_W-1:0] core_a,
   output logic [7:0]        core_d,
   input  logic [7:0]        core_q,
   output logic              overflow,
   // mixer
   input  logic [1:0]        mix_mode,
   input  logic [OUT_W-1:0]  left_in,
   input  logic [OUT_W-1:0]  right_in,
   output logic [OUT_W-1:0]  left_out,
   output logic [OUT_W-1:0]  right_out
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_ENT_W = ADDR_W + 8;
   localparam logic [c_PTR_W:0] c_FULL_CNT = (c_PTR_W + 1)'(FIFO_DEPTH);

   // Read-side FSM encoding
   localparam logic [2:0] c_ST_IDLE     = 3'd0;
   localparam logic [2:0] c_ST_RD_DRAIN = 3'd1;
   localparam logic [2:0] c_ST_RD_REQ   = 3'd2;
   localparam logic [2:0] c_ST_RD_WAIT  = 3'd3;
   localparam logic [2:0] c_ST_RD_HOLD  = 3'd4;

   localparam logic [1:0] c_MIX_STEREO = 2'b00;
   localparam logic [1:0] c_MIX_AVG    = 2'b01;
   localparam logic [1:0] c_MIX_SWAP   = 2'b10;
   localparam logic [1:0] c_MIX_SAT    = 2'b11;

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_nrd_sync;
   logic [SYNC_STAGES-1:0] r_nwr_sync;
   logic                   r_nrd_dly;
   logic                   r_nwr_dly;
   logic                   w_nrd_s;
   logic                   w_nwr_s;
   logic                   w_slot_sel;
   logic                   w_rd_edge;
   logic                   w_wr_edge;

   logic [c_ENT_W-1:0]     r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0]     r_wr_ptr;
   logic [c_PTR_W-1:0]     r_rd_ptr;
   logic [c_PTR_W:0]       r_count;
   logic                   w_empty;
   logic                   w_full;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_drop;
   logic [c_ENT_W-1:0]     w_head;
   logic [ADDR_W-1:0]      w_head_a;
   logic [7:0]             w_head_d;
   logic                   r_overflow;

   logic [2:0]             r_state;
   logic [2:0]             w_state_nxt;
   logic                   w_rd_busy;
   logic                   w_rd_pending;
   logic [ADDR_W-1:0]      r_rd_addr;
   logic [7:0]             r_rd_data;

   logic [OUT_W:0]         w_sum;
   logic [OUT_W-1:0]       w_avg;
   logic [OUT_W-1:0]       w_sat;
   logic [OUT_W-1:0]       r_left;
   logic [OUT_W-1:0]       r_right;

   // ------------------------------------------------------------------------
   // Strobe synchronisers plus one delay flop for edge detection; they idle
   // high so a reset never fabricates a falling edge.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge slot_nreset) begin
      if (!slot_nreset) begin
         r_nrd_sync <= '1;
         r_nwr_sync <= '1;
         r_nrd_dly  <= 1'b1;
         r_nwr_dly  <= 1'b1;
      end else begin
         r_nrd_sync <= {r_nrd_sync[SYNC_STAGES-2:0], slot_nrd};
         r_nwr_sync <= {r_nwr_sync[SYNC_STAGES-2:0], slot_nwr};
         r_nrd_dly  <= r_nrd_sync[SYNC_STAGES-1];
         r_nwr_dly  <= r_nwr_sync[SYNC_STAGES-1];
      end
   end

   // Falling edges on the synchronised strobes, qualified by the raw selects
   // (the selects are stable long before the strobes move on a Z80 bus).
   assign w_nrd_s    = r_nrd_sync[SYNC_STAGES-1];
   assign w_nwr_s    = r_nwr_sync[SYNC_STAGES-1];
   assign w_slot_sel = ~slot_nsltsl & ~slot_nmerq;
   assign w_rd_edge  = r_nrd_dly & ~w_nrd_s & w_slot_sel;
   assign w_wr_edge  = r_nwr_dly & ~w_nwr_s & w_slot_sel;

   // ------------------------------------------------------------------------
   // Write-post FIFO control. Pops are suppressed while a read is being
   // issued or awaited so the core never sees both requests at once.
   // ------------------------------------------------------------------------
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == c_FULL_CNT);
   assign w_rd_busy = (r_state == c_ST_RD_REQ) || (r_state == c_ST_RD_WAIT);
   assign w_pop     = ~w_empty & core_wr_ready & ~w_rd_busy;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign w_push    = w_wr_edge & (~w_full | w_pop);
   assign w_drop    = w_wr_edge & w_full & ~w_pop;
   assign w_head    = r_mem[r_rd_ptr];
   assign w_head_a  = w_head[c_ENT_W-1:8];
   assign w_head_d  = w_head[7:0];

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {slot_a, slot_d_in};
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge slot_nreset) begin
      if (!slot_nreset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky overflow flag; only reset clears it.
   always_ff @(posedge clk or negedge slot_nreset) begin
      if (!slot_nreset) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Read FSM next-state logic. With an empty FIFO a read edge goes straight
   // to RD_REQ; otherwise it waits in RD_DRAIN behind the posted writes.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (w_rd_edge) begin
               w_state_nxt = w_empty ? c_ST_RD_REQ : c_ST_RD_DRAIN;
            end
         end
         c_ST_RD_DRAIN: begin
            if (w_empty) begin
               w_state_nxt = c_ST_RD_REQ;
            end
         end
         c_ST_RD_REQ: begin
            w_state_nxt = c_ST_RD_WAIT;
         end
         c_ST_RD_WAIT: begin
            if (core_rvalid) begin
               w_state_nxt = c_ST_RD_HOLD;
            end
         end
         c_ST_RD_HOLD: begin
            if (w_nrd_s) begin
               w_state_nxt = c_ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = c_ST_IDLE;
         end
      endcase
   end

   // Read FSM state register, read-address latch and read-data capture.
   always_ff @(posedge clk or negedge slot_nreset) begin
      if (!slot_nreset) begin
         r_state   <= c_ST_IDLE;
         r_rd_addr <= '0;
         r_rd_data <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == c_ST_IDLE) && w_rd_edge) begin
            r_rd_addr <= slot_a;
         end
         if ((r_state == c_ST_RD_WAIT) && core_rvalid) begin
            r_rd_data <= core_q;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Core and slot outputs. Address/data buses are zero unless a request is
   // active so the core sees a quiet bus between transactions.
   // ------------------------------------------------------------------------
   assign w_rd_pending = (r_state == c_ST_RD_DRAIN) || w_rd_busy;

   assign core_wrreq = w_pop;
   assign core_rdreq = (r_state == c_ST_RD_REQ);
   assign core_a     = core_rdreq ? r_rd_addr : (w_pop ? w_head_a : '0);
   assign core_d     = w_pop ? w_head_d : '0;
   assign overflow   = r_overflow;

   // Stall the CPU while a read is outstanding or no write slot is free.
   assign slot_nwait = ~(w_rd_pending | w_full);
   // Raw pins gate the driver so the bus is released without sync delay.
   assign slot_d_oe  = (r_state == c_ST_RD_HOLD) & ~slot_nsltsl & ~slot_nrd;
   assign slot_d_out = r_rd_data;

   // ------------------------------------------------------------------------
   // Mixer: sums carried at OUT_W+1 bits so neither mode can wrap.
   // ------------------------------------------------------------------------
   assign w_sum = {1'b0, left_in} + {1'b0, right_in};
   assign w_avg = w_sum[OUT_W:1];
   assign w_sat = w_sum[OUT_W] ? {OUT_W{1'b1}} : w_sum[OUT_W-1:0];

   // Registered mixer output, one clock of latency.
   always_ff @(posedge clk or negedge slot_nreset) begin
      if (!slot_nreset) begin
         r_left  <= '0;
         r_right <= '0;
      end else begin
         case (mix_mode)
            c_MIX_AVG: begin
               r_left  <= w_avg;
               r_right <= w_avg;
            end
            c_MIX_SWAP: begin
               r_left  <= right_in;
               r_right <= left_in;
            end
            c_MIX_SAT: begin
               r_left  <= w_sat;
               r_right <= w_sat;
            end
            c_MIX_STEREO: begin
               r_left  <= left_in;
               r_right <= right_in;
            end
            default: begin
               r_left  <= left_in;
               r_right <= right_in;
            end
         endcase
      end
   end

   assign left_out  = r_left;
   assign right_out = r_right;

endmodule
`default_nettype wire

// File: tb/tb_wts_slot_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_wts_slot_bridge
// Description : Self-checking bench for wts_slot_bridge. Posted writes and
//               mixer results are queued as expectations when driven and
//               compared when the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wts_slot_bridge;

   localparam int S     = 2;
   localparam int AW    = 15;
   localparam int DEPTH = 4;
   localparam int OW    = 12;

   logic          clk = 1'b0;
   logic          slot_nreset;
   logic [AW-1:0] slot_a;
   logic [7:0]    slot_d_in;
   logic [7:0]    slot_d_out;
   logic          slot_d_oe;
   logic          slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr;
   logic          slot_nwait;
   logic          core_wrreq, core_wr_ready, core_rdreq, core_rvalid;
   logic [AW-1:0] core_a;
   logic [7:0]    core_d, core_q;
   logic          overflow;
   logic [1:0]    mix_mode;
   logic [OW-1:0] left_in, right_in, left_out, right_out;

   always #5 clk = ~clk;

   wts_slot_bridge #(
      .SYNC_STAGES(S), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .OUT_W(OW)
   ) u_dut (
      .clk(clk), .slot_nreset(slot_nreset),
      .slot_a(slot_a), .slot_d_in(slot_d_in), .slot_d_out(slot_d_out),
      .slot_d_oe(slot_d_oe), .slot_nsltsl(slot_nsltsl), .slot_nmerq(slot_nmerq),
      .slot_nrd(slot_nrd), .slot_nwr(slot_nwr), .slot_nwait(slot_nwait),
      .core_wrreq(core_wrreq), .core_wr_ready(core_wr_ready),
      .core_rdreq(core_rdreq), .core_rvalid(core_rvalid),
      .core_a(core_a), .core_d(core_d), .core_q(core_q), .overflow(overflow),
      .mix_mode(mix_mode), .left_in(left_in), .right_in(right_in),
      .left_out(left_out), .right_out(right_out)
   );

   // Counters and scoreboards
   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_wr     = 0;
   int n_rd     = 0;
   int last_wr_cyc = 0;
   int last_rd_cyc = 0;
   logic [AW-1:0] last_rd_a;

   typedef struct packed { logic [AW-1:0] a; logic [7:0] d; } wr_t;
   wr_t wr_q[$];

   typedef struct { int due; logic [OW-1:0] l; logic [OW-1:0] r; } mix_exp_t;
   mix_exp_t mix_q[$];

   typedef struct {
      logic [1:0] mode; logic [OW-1:0] l; logic [OW-1:0] r;
      logic [OW-1:0] el; logic [OW-1:0] er;
   } mix_vec_t;
   mix_vec_t vecs[10];

   // Snapshots of DUT outputs taken at the falling edge
   logic          s_nwait, s_oe, s_ovf, s_wrreq, s_rdreq;
   logic [7:0]    s_dout, s_d;
   logic [AW-1:0] s_a;
   logic [OW-1:0] s_l, s_r;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: sample/score at negedge, return just after the next posedge.
   task automatic step();
      wr_t      e;
      mix_exp_t m;
      @(negedge clk);
      cyc++;
      s_nwait = slot_nwait; s_oe = slot_d_oe; s_ovf = overflow;
      s_wrreq = core_wrreq; s_rdreq = core_rdreq; s_dout = slot_d_out;
      s_d = core_d; s_a = core_a; s_l = left_out; s_r = right_out;
      if (core_wrreq === 1'b1) begin
         n_wr++;
         last_wr_cyc = cyc;
         if (wr_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_wrreq actual a=0x%0h d=0x%0h required no pulse (cycle %0d)",
                     core_a, core_d, cyc);
         end else begin
            e = wr_q.pop_front();
            chk("wr_addr", 32'(core_a), 32'(e.a));
            chk("wr_data", 32'(core_d), 32'(e.d));
         end
      end
      if (core_rdreq === 1'b1) begin
         n_rd++;
         last_rd_cyc = cyc;
         last_rd_a   = core_a;
      end
      if (mix_q.size() > 0 && mix_q[0].due == cyc) begin
         m = mix_q.pop_front();
         chk("mix_left", 32'(left_out), 32'(m.l));
         chk("mix_right", 32'(right_out), 32'(m.r));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d);
      slot_a = a; slot_d_in = d; slot_nsltsl = 1'b0; slot_nmerq = 1'b0; slot_nwr = 1'b0;
      repeat (5) step();
      slot_nwr = 1'b1; slot_nsltsl = 1'b1; slot_nmerq = 1'b1;
      repeat (5) step();
   endtask

   task automatic expect_write(input logic [AW-1:0] a, input logic [7:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      wr_q.push_back(e);
   endtask

   task automatic start_read(input logic [AW-1:0] a);
      slot_a = a; slot_nsltsl = 1'b0; slot_nmerq = 1'b0; slot_nrd = 1'b0;
   endtask

   // Wait for rdreq, return data after dly clocks, check hold and release.
   task automatic finish_read(input logic [AW-1:0] a, input logic [7:0] q,
                              input int dly, output int wr_at_rd);
      int start_rd;
      start_rd = n_rd;
      wr_at_rd = n_wr;
      for (int k = 0; k < 80 && n_rd == start_rd; k++) step();
      if (n_rd == start_rd) begin
         checks++;
         failures++;
         $display("FAIL rdreq_timeout actual=no rdreq required=rdreq within 80 clocks");
      end else begin
         wr_at_rd = n_wr;
         chk("rd_addr", 32'(last_rd_a), 32'(a));
         for (int i = 1; i < dly; i++) begin
            step();
            chk("nwait_rd_wait", 32'(s_nwait), 32'd0);
         end
         core_rvalid = 1'b1; core_q = q;
         step();
         chk("nwait_at_rvalid", 32'(s_nwait), 32'd0);
         chk("oe_at_rvalid", 32'(s_oe), 32'd0);
         core_rvalid = 1'b0; core_q = 8'h00;
         step();
         chk("oe_hold", 32'(s_oe), 32'd1);
         chk("dout_hold", 32'(s_dout), 32'(q));
         chk("nwait_hold", 32'(s_nwait), 32'd1);
         slot_nrd = 1'b1;
         step();
         chk("oe_release", 32'(s_oe), 32'd0);
         slot_nsltsl = 1'b1; slot_nmerq = 1'b1;
         repeat (S + 3) step();
         chk("nwait_idle", 32'(s_nwait), 32'd1);
      end
   endtask

   // Global time bound
   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base_wr, base_rd, t0, wr_at;

      vecs[0] = '{2'b00, 12'hC00, 12'h600, 12'hC00, 12'h600};
      vecs[1] = '{2'b01, 12'hC00, 12'h600, 12'h900, 12'h900};
      vecs[2] = '{2'b10, 12'hC00, 12'h600, 12'h600, 12'hC00};
      vecs[3] = '{2'b11, 12'hC00, 12'h600, 12'hFFF, 12'hFFF};
      vecs[4] = '{2'b11, 12'h800, 12'h7FF, 12'hFFF, 12'hFFF};
      vecs[5] = '{2'b01, 12'h800, 12'h7FF, 12'h7FF, 12'h7FF};
      vecs[6] = '{2'b01, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
      vecs[7] = '{2'b11, 12'h001, 12'h002, 12'h003, 12'h003};
      vecs[8] = '{2'b10, 12'h123, 12'h456, 12'h456, 12'h123};
      vecs[9] = '{2'b00, 12'h000, 12'hABC, 12'h000, 12'hABC};

      slot_nreset = 1'b0;
      slot_a = '0; slot_d_in = 8'h00;
      slot_nsltsl = 1'b1; slot_nmerq = 1'b1; slot_nrd = 1'b1; slot_nwr = 1'b1;
      core_wr_ready = 1'b0; core_rvalid = 1'b0; core_q = 8'h00;
      mix_mode = 2'b00; left_in = 12'h123; right_in = 12'h456;

      // Reset state
      repeat (3) step();
      chk("rst_dout", 32'(s_dout), 32'd0);
      chk("rst_oe", 32'(s_oe), 32'd0);
      chk("rst_nwait", 32'(s_nwait), 32'd1);
      chk("rst_wrreq", 32'(s_wrreq), 32'd0);
      chk("rst_rdreq", 32'(s_rdreq), 32'd0);
      chk("rst_core_a", 32'(s_a), 32'd0);
      chk("rst_core_d", 32'(s_d), 32'd0);
      chk("rst_overflow", 32'(s_ovf), 32'd0);
      chk("rst_left", 32'(s_l), 32'd0);
      chk("rst_right", 32'(s_r), 32'd0);
      slot_nreset = 1'b1;
      left_in = '0; right_in = '0;
      repeat (2) step();

      // Single posted write and its latency
      core_wr_ready = 1'b1;
      base_wr = n_wr;
      t0 = cyc;
      expect_write(15'h1800, 8'h5A);
      do_write(15'h1800, 8'h5A);
      chk("single_wr_count", 32'(n_wr - base_wr), 32'd1);
      chk("single_wr_latency", 32'(last_wr_cyc - t0), 32'(S + 2));

      // Fill the FIFO, overflow on the fifth write, then drain in order
      core_wr_ready = 1'b0;
      base_wr = n_wr;
      for (int i = 0; i < 5; i++) begin
         if (i < DEPTH) expect_write(15'h0100 + 15'(i), 8'h10 + 8'(i));
         do_write(15'h0100 + 15'(i), 8'h10 + 8'(i));
         if (i == 2) chk("nwait_not_full", 32'(s_nwait), 32'd1);
         if (i == 3) begin
            chk("nwait_full", 32'(s_nwait), 32'd0);
            chk("ovf_at_full", 32'(s_ovf), 32'd0);
         end
         if (i == 4) chk("ovf_after_drop", 32'(s_ovf), 32'd1);
      end
      chk("no_pop_unready", 32'(n_wr - base_wr), 32'd0);
      core_wr_ready = 1'b1;
      repeat (10) step();
      chk("drain_count", 32'(n_wr - base_wr), 32'd4);
      chk("drain_queue_left", 32'(wr_q.size()), 32'd0);
      chk("nwait_after_drain", 32'(s_nwait), 32'd1);

      // Read ordered behind two posted writes
      core_wr_ready = 1'b0;
      base_wr = n_wr;
      base_rd = n_rd;
      expect_write(15'h0A00, 8'h11);
      do_write(15'h0A00, 8'h11);
      expect_write(15'h0A01, 8'h22);
      do_write(15'h0A01, 8'h22);
      start_read(15'h1900);
      repeat (10) step();
      chk("rd_blocked", 32'(n_rd - base_rd), 32'd0);
      chk("nwait_drain", 32'(s_nwait), 32'd0);
      core_wr_ready = 1'b1;
      finish_read(15'h1900, 8'hA5, 3, wr_at);
      chk("wr_before_rd", 32'(wr_at - base_wr), 32'd2);

      // Read while the slot is not selected is ignored
      base_rd = n_rd;
      slot_a = 15'h1234; slot_nsltsl = 1'b1; slot_nmerq = 1'b0; slot_nrd = 1'b0;
      repeat (10) step();
      chk("unsel_rdreq", 32'(n_rd - base_rd), 32'd0);
      chk("unsel_oe", 32'(s_oe), 32'd0);
      chk("unsel_nwait", 32'(s_nwait), 32'd1);
      slot_nrd = 1'b1; slot_nmerq = 1'b1;
      repeat (5) step();

      // Mixer vectors, one per clock, scored one clock later
      for (int i = 0; i < 10; i++) begin
         mix_exp_t m;
         mix_mode = vecs[i].mode; left_in = vecs[i].l; right_in = vecs[i].r;
         m.due = cyc + 2; m.l = vecs[i].el; m.r = vecs[i].er;
         mix_q.push_back(m);
         step();
      end
      repeat (3) step();
      chk("mix_drained", 32'(mix_q.size()), 32'd0);

      // Reset while in RD_WAIT with two writes queued
      core_wr_ready = 1'b1;
      base_rd = n_rd;
      start_read(15'h0200);
      for (int k = 0; k < 40 && n_rd == base_rd; k++) step();
      chk("rst_test_rdreq", 32'(n_rd - base_rd), 32'd1);
      base_wr = n_wr;
      do_write(15'h0300, 8'h33);
      do_write(15'h0301, 8'h44);
      chk("no_pop_in_wait", 32'(n_wr - base_wr), 32'd0);
      chk("nwait_in_wait", 32'(s_nwait), 32'd0);
      mix_mode = 2'b00; left_in = 12'hABC; right_in = 12'h000;
      slot_nreset = 1'b0;
      slot_nrd = 1'b1; slot_nsltsl = 1'b1; slot_nmerq = 1'b1;
      repeat (2) step();
      chk("mid_rst_nwait", 32'(s_nwait), 32'd1);
      chk("mid_rst_oe", 32'(s_oe), 32'd0);
      chk("mid_rst_dout", 32'(s_dout), 32'd0);
      chk("mid_rst_overflow", 32'(s_ovf), 32'd0);
      chk("mid_rst_core_a", 32'(s_a), 32'd0);
      chk("mid_rst_left", 32'(s_l), 32'd0);
      slot_nreset = 1'b1;
      left_in = '0;
      base_wr = n_wr;
      base_rd = n_rd;
      repeat (10) step();
      chk("post_rst_no_wr", 32'(n_wr - base_wr), 32'd0);
      chk("post_rst_no_rd", 32'(n_rd - base_rd), 32'd0);
      t0 = cyc;
      start_read(15'h0123);
      finish_read(15'h0123, 8'h3C, 1, wr_at);
      chk("post_rst_rd_latency", 32'(last_rd_cyc - t0), 32'(S + 2));
      chk("post_rst_rd_no_wr", 32'(wr_at - base_wr), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wts_slot_bridge.md
# wts_slot_bridge

Parametrised cartridge-slot front-end for the Wave Table Sound core, sitting between the MSX slot pins and `wts_core`. It synchronises the slot strobes and posts writes through a small FIFO so the core can accept them at its own pace. Reads are ordered behind pending writes, and slot wait-state (`slot_nwait`) is generated while read data is not ready. It also registers a multi-mode output mixer (stereo, mono average, swap, mono saturating sum) of configurable width.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser flops on `slot_nrd`/`slot_nwr` (legal 2..4).
- `ADDR_W`, 15: slot address width.
- `FIFO_DEPTH`, 4: write-post FIFO entries (power of two, 2..16).
- `OUT_W`, 12: audio sample width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, 21.47727 MHz.
- `slot_nreset` in 1: asynchronous active-low reset.
- `slot_a` in ADDR_W: slot address.
- `slot_d_in` in 8: slot data in.
- `slot_d_out` out 8: read data to pad.
- `slot_d_oe` out 1: pad output enable.
- `slot_nsltsl`, `slot_nmerq`, `slot_nrd`, `slot_nwr` in 1 each: raw active-low slot strobes.
- `slot_nwait` out 1: active-low wait request, 0 = stall CPU.
- `core_wrreq` out 1: one-cycle write pulse to core.
- `core_wr_ready` in 1: core can accept a write this cycle.
- `core_rdreq` out 1: one-cycle read pulse to core.
- `core_rvalid` in 1: `core_q` valid this cycle.
- `core_a` out ADDR_W, `core_d` out 8: request address and write data.
- `core_q` in 8: core read data.
- `overflow` out 1: sticky flag, a write was dropped.
- `mix_mode` in 2: 00 stereo, 01 mono average, 10 swap L/R, 11 mono saturating sum.
- `left_in`, `right_in` in OUT_W: unsigned core samples.
- `left_out`, `right_out` out OUT_W: registered mixer output.

## Operation
- Synchroniser: `slot_nrd`/`slot_nwr` each pass through SYNC_STAGES flops, then one extra delay flop. A falling edge is detected on the synchronised value (prev=1, now=0) and qualified with raw `slot_nsltsl`=0 and `slot_nmerq`=0.
- Write edge: {`slot_a`, `slot_d_in`} is pushed into the FIFO.
  - If the FIFO is full, the write is dropped and `overflow` is set (cleared only by reset).
- Drain: when the FIFO is not empty, `core_wr_ready`=1, and the FSM is not in RD_REQ or RD_WAIT, the head is popped with a `core_wrreq` pulse. `core_a`/`core_d` carry the head entry in the same cycle. At most one pop per cycle.
- A push and a pop in the same cycle are both honoured and the count is unchanged. This applies when full too: the pop frees the slot first, so there is no overflow.
- Read FSM states: IDLE, RD_DRAIN, RD_REQ, RD_WAIT, RD_HOLD.
  - IDLE to RD_DRAIN on a read edge. `slot_a` is latched into the read address.
  - RD_DRAIN to RD_REQ when the FIFO is empty (immediately if it is already empty), so reads never overtake posted writes.
  - RD_REQ: `core_rdreq`=1 for one cycle with `core_a` = latched address, then go to RD_WAIT.
  - RD_WAIT: capture `core_q` on `core_rvalid`, then go to RD_HOLD.
  - RD_HOLD to IDLE when the synchronised `slot_nrd` returns to 1.
- `slot_nwait`=0 from the cycle after the read edge through RD_WAIT. It is 1 in RD_HOLD and IDLE.
- `slot_nwait` is also 0 while the FIFO is full, so the CPU is not allowed to post another write.
- `slot_d_oe` = (state==RD_HOLD) & ~`slot_nsltsl` & ~`slot_nrd`. The raw pins keep bus release combinational. `slot_d_out` is the captured byte.
- Mixer, registered every cycle. Sums are formed at OUT_W+1 bits.
  - Mode 01: both outputs = (L+R)>>1.
  - Mode 11: both outputs = min(L+R, 2^OUT_W−1).
  - Mode 10: outputs are R, L.
  - Mode 00: passthrough.
- Reset mid-operation: the FIFO empties, the FSM goes to IDLE, and the synchroniser flops go to 1. Any pending write or read is abandoned without a core pulse.

## Timing
- Reset values:
  - `slot_d_out`=0, `slot_d_oe`=0, `slot_nwait`=1.
  - `core_wrreq`=0, `core_rdreq`=0, `core_a`=0, `core_d`=0.
  - `overflow`=0, `left_out`=0, `right_out`=0.
- Edge detection happens SYNC_STAGES+1 clocks after the pin falls.
- Write latency: an entry pushed in cycle N can pop at N+1 at the earliest, if the FIFO was empty and the core is ready.
- Read with an empty FIFO: edge at E, `core_rdreq` at E+1. Data is driven the cycle after `core_rvalid`.
- `slot_nwait` deasserts in the same cycle that `slot_d_oe` asserts.
- Mixer latency is 1 clock.
- A read edge and a write edge in the same cycle are impossible on the Z80 bus and need not be handled. An edge with `slot_nsltsl`=1 is ignored.

## Test plan
- Single write A=0x1800, D=0x5A with `core_wr_ready`=1 → exactly one `core_wrreq`, with `core_a`=0x1800 and `core_d`=0x5A, SYNC_STAGES+2 clocks after the `slot_nwr` fall.
- `core_wr_ready`=0, then 5 writes with FIFO_DEPTH=4 → `slot_nwait`=0 after the 4th and `overflow`=1 after the 5th. Releasing ready yields 4 pulses in order, then `slot_nwait`=1.
- 2 posted writes with ready held low, then a read of 0x1900 → no `core_rdreq` until both writes pop. With `core_q`=0xA5 and `core_rvalid` 3 clocks after `rdreq`, `slot_d_out`=0xA5 and `slot_d_oe`=1 while `slot_nrd`=0, and `slot_nwait` is low until then.
- Read with `slot_nsltsl`=1 → no `core_rdreq`, `slot_d_oe` stays 0, `slot_nwait` stays 1.
- Mixer with OUT_W=12, L=0xC00, R=0x600 → mode 00 gives 0xC00/0x600, mode 01 gives 0x900/0x900, mode 10 gives 0x600/0xC00, mode 11 gives 0xFFF/0xFFF. Each appears 1 clock after the mode change.
- Assert `slot_nreset` in RD_WAIT with 2 entries queued → outputs return to their reset values, no further `core_wrreq`/`core_rdreq` pulses, and the next read behaves as from an empty FIFO.
